// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, line levels and width helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Index width for a range of n values, never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_CNT_W = clog2w(40);
    localparam int DEF_PTR_W = clog2w(4);

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO shared by the UART transmit and receive paths.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = clog2w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // Full is judged before any same-edge pop, so a push into a full FIFO is dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO feeding an 8N1 serializer with a registered Tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 40,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] w_data,
    input  logic                 we,
    output logic                 full,
    output logic                 tx_empty,
    output logic                 tx_busy,
    output logic                 Tx
);

    localparam int CNT_W = clog2w(CLKS_PER_BIT);
    localparam int BIT_W = clog2w(DATA_BITS);

    tx_state_e                   state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [BIT_W-1:0]            bit_q;
    logic [DATA_BITS-1:0]        shift_q;
    logic                        tx_q;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q;
`endif

    logic [DATA_BITS-1:0]        fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_empty, fifo_full;
    logic                        bit_end, pop;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (we),
        .pop   (pop),
        .din   (w_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    // Loads happen from IDLE or on the last stop cycle, giving gap-free back-to-back frames.
    assign pop      = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_end));
    assign full     = fifo_full;
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_empty = (fifo_count == '0) && (state_q == ST_IDLE);
    assign Tx       = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (pop) begin
            state_q  <= ST_START;
            cnt_q    <= '0;
            shift_q  <= fifo_dout;
            tx_q     <= START_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^fifo_dout;
`endif
        end else if (state_q != ST_IDLE) begin
            cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
                case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= ST_STOP;
                            tx_q    <= STOP_LEVEL;
`endif
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        tx_q    <= STOP_LEVEL;
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                        tx_q    <= IDLE_LEVEL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: line-level reference model (byte queue + pending line levels).
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int DB    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [DB-1:0] w_data;
    logic          full, tx_empty, tx_busy, Tx;

    int errors = 0;
    int checks = 0;

    logic [DB-1:0] fq[$];
    logic          line[$];

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DATA_BITS(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .w_data   (w_data),
        .we       (we),
        .full     (full),
        .tx_empty (tx_empty),
        .tx_busy  (tx_busy),
        .Tx       (Tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Append one full frame's worth of per-cycle line levels.
    function automatic void load_frame(input logic [DB-1:0] b);
        logic par;
        par = ^b;
        for (int k = 0; k < CPB; k++) line.push_back(1'b0);
        for (int i = 0; i < DB; i++)
            for (int k = 0; k < CPB; k++) line.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        for (int k = 0; k < CPB; k++) line.push_back(par);
`endif
        for (int k = 0; k < CPB; k++) line.push_back(1'b1);
    endfunction

    task automatic step(input logic r, input logic w, input logic [DB-1:0] d);
        logic full_before;
        rst = r; we = w; w_data = d;
        @(posedge clk);
        if (r) begin
            fq.delete();
            line.delete();
        end else begin
            full_before = (fq.size() == DEPTH);
            if (line.size() > 0) void'(line.pop_front());
            if (line.size() == 0 && fq.size() > 0) load_frame(fq.pop_front());
            if (w && !full_before) fq.push_back(d);
        end
        #1;
        check("Tx",       32'(Tx),       32'((line.size() > 0) ? line[0] : 1'b1));
        check("tx_busy",  32'(tx_busy),  32'(line.size() > 0));
        check("tx_empty", 32'(tx_empty), 32'(line.size() == 0 && fq.size() == 0));
        check("full",     32'(full),     32'(fq.size() == DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [DB-1:0] burst4 [4];
        burst4 = '{8'h01, 8'h09, 8'h00, 8'h08};
        rst = 1'b1; we = 1'b0; w_data = '0;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 8'hFF);
        idle(20);

        // Single byte: tx_empty returns exactly 41 edges after the write.
        step(1'b0, 1'b1, 8'h08);
        idle(40);
        check("tx_empty_N40", 32'(tx_empty), 32'd0);
        idle(1);
        check("tx_empty_N41", 32'(tx_empty), 32'd1);
        idle(5);

        // Four consecutive writes: full never asserts, frames back-to-back.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, burst4[i]);
            check("burst4_not_full", 32'(full), 32'd0);
        end
        idle(170);

        // Six writes: sixth is dropped once four are queued behind the active frame.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'h31 + 8'(i));
            if (i == 4) check("full_after_5th", 32'(full), 32'd1);
        end
        idle(5 * (DB + 3) * CPB + 10);

        // Reset during data bit 3 of 8'h2A with two bytes queued.
        step(1'b0, 1'b1, 8'h2A);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        idle(16);
        step(1'b1, 1'b1, 8'h55);
        check("rst_tx", 32'(Tx), 32'd1);
        check("rst_empty", 32'(tx_empty), 32'd1);
        idle(60);

`ifdef UART_TX_PARITY_EN
        step(1'b0, 1'b1, 8'h07);
        idle(50);
`endif

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(1'b0 || ($urandom_range(0, 599) == 0), $urandom_range(0, 5) == 0, DB'($urandom));
        idle(6 * (DB + 3) * CPB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
